// File: rtl/midi_pkg.sv
// Shared constants, FSM state type and message-length helper for the MIDI transmitter.
// Optional build macro: MIDI_RUNNING_STATUS_EN (used by midi_tx).
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // Bytes on the wire including the status byte; 0 marks a nibble we never send.
  function automatic logic [1:0] midi_msg_len(input logic [3:0] s);
    logic [1:0] n;
    case (s)
      NOTE_OFF,
      NOTE_ON,
      POLY_AT,
      CTRL,
      PITCH:   n = 2'd3;
      PROG,
      CHAN_AT: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_tx_uart.sv
// 8N1 byte serialiser, LSB first, BAUD_CYCLES clocks per bit.
// byte_ready also rises in the last stop-bit cycle so bytes chain gap-free.
module uart_byte_tx
  import midi_pkg::*;
#(
  parameter int BAUD_CYCLES = 3200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx_out
);

  localparam int CW =
    (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(BAUD_CYCLES - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          load;

  assign bit_end    = (baud_cnt == LAST);
  assign byte_done  = (state == S_STOP) && bit_end;
  assign byte_ready = (state == S_IDLE) || byte_done;
  assign load       = byte_valid && byte_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (load) begin
      state    <= S_START;
      shreg    <= byte_data;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (state != S_IDLE) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end) begin
        unique case (state)
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
          S_DATA: begin
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          S_STOP:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Decoded from state so an async reset forces the line high at once.
  always_comb begin
    tx_out = 1'b1;
    unique case (state)
      S_START: tx_out = 1'b0;
      S_DATA:  tx_out = shreg[0];
      S_STOP:  tx_out = 1'b1;
      default: tx_out = 1'b1;
    endcase
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI channel-message transmitter: sequences status/data bytes into uart_byte_tx.
// Optional macro MIDI_RUNNING_STATUS_EN omits a repeated status byte.
module midi_tx
  import midi_pkg::*;
#(
  parameter int BAUD_CYCLES = 3200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status,
  input  logic [3:0] channel,
  input  logic [7:0] data_byte1,
  input  logic [7:0] data_byte2,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       done_out
);

  logic       busy;
  logic       done_q;
  logic [1:0] byte_idx;
  logic [1:0] msg_len;
  logic [7:0] nxt1;
  logic [7:0] nxt2;

  logic [7:0] stat_byte;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [1:0] len_raw;
  logic [1:0] len_eff;
  logic       skip;
  logic       accept_msg;
  logic [7:0] first_byte;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_done;
  logic       last_byte;

  assign stat_byte = {status, channel};
  assign d1        = data_byte1 & 8'h7F;
  assign d2        = data_byte2 & 8'h7F;
  assign len_raw   = midi_msg_len(status);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] rs_byte;
  logic       rs_valid;

  assign skip = rs_valid && (rs_byte == stat_byte);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rs_byte  <= '0;
      rs_valid <= 1'b0;
    end else if (accept_msg) begin
      rs_byte  <= stat_byte;
      rs_valid <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  assign len_eff    = len_raw - {1'b0, skip};
  assign accept_msg = valid_in && ready_out && (len_raw != 2'd0);
  assign first_byte = skip ? d1 : stat_byte;
  assign last_byte  = (byte_idx == msg_len);

  // First byte goes straight to the serialiser so tx falls the next cycle.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = first_byte;
    if (busy) begin
      byte_valid = !last_byte;
      byte_data  = (byte_idx == 2'd1) ? nxt1 : nxt2;
    end else begin
      byte_valid = accept_msg;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy     <= 1'b0;
      done_q   <= 1'b0;
      byte_idx <= '0;
      msg_len  <= '0;
      nxt1     <= '0;
      nxt2     <= '0;
    end else begin
      done_q <= busy && byte_done && last_byte;
      if (accept_msg) begin
        busy     <= 1'b1;
        byte_idx <= 2'd1;
        msg_len  <= len_eff;
        nxt1     <= skip ? d2 : d1;
        nxt2     <= d2;
      end else if (busy) begin
        if (byte_valid && byte_ready) begin
          byte_idx <= byte_idx + 2'd1;
        end else if (byte_done && last_byte) begin
          busy     <= 1'b0;
          byte_idx <= '0;
        end
      end
    end
  end

  assign ready_out = !busy;
  assign done_out  = done_q;

  uart_byte_tx #(
    .BAUD_CYCLES(BAUD_CYCLES)
  ) u_uart (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .tx_out    (tx_out)
  );

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: a per-cycle line-level model plus decoded-byte literal checks.
// Build with +define+MIDI_RUNNING_STATUS_EN to cover running status.
module tb_midi_tx;

  localparam int B = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] status = '0;
  logic [3:0] channel = '0;
  logic [7:0] data_byte1 = '0;
  logic [7:0] data_byte2 = '0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       tx_out;
  logic       done_out;

  midi_tx #(.BAUD_CYCLES(B)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .status    (status),
    .channel   (channel),
    .data_byte1(data_byte1),
    .data_byte2(data_byte2),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .done_out  (done_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk1(string nm, logic got, logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic void chk_int(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endfunction

  function automatic void chk8(string nm, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endfunction

  // Model: queue of per-cycle {tx, done} levels still to come.
  logic [1:0] q[$];
  logic exp_tx = 1'b1;
  logic exp_done = 1'b0;
  logic exp_ready = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_sb = '0;
  logic       last_ok = 1'b0;
`endif

  function automatic int msg_len(logic [3:0] s);
    if (s >= 4'h8 && s <= 4'hB) return 3;
    if (s == 4'hE) return 3;
    if (s == 4'hC || s == 4'hD) return 2;
    return 0;
  endfunction

  function automatic void model_accept();
    logic [7:0] b[$];
    logic [7:0] sb;
    int n;
    n = msg_len(status);
    sb = {status, channel};
    if (n == 0) return;
    b.push_back(sb);
    b.push_back({1'b0, data_byte1[6:0]});
    if (n == 3) b.push_back({1'b0, data_byte2[6:0]});
`ifdef MIDI_RUNNING_STATUS_EN
    if (last_ok && last_sb == sb) void'(b.pop_front());
    last_sb = sb;
    last_ok = 1'b1;
`endif
    foreach (b[k]) begin
      repeat (B) q.push_back(2'b00);
      for (int j = 0; j < 8; j++)
        repeat (B) q.push_back({b[k][j], 1'b0});
      repeat (B) q.push_back(2'b10);
    end
    q.push_back(2'b11);
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q.delete();
      exp_tx = 1'b1;
      exp_done = 1'b0;
      exp_ready = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
      last_ok = 1'b0;
`endif
    end else begin
      if (valid_in && exp_ready) model_accept();
      if (q.size() > 0) begin
        {exp_tx, exp_done} = q.pop_front();
      end else begin
        exp_tx = 1'b1;
        exp_done = 1'b0;
      end
      exp_ready = (q.size() == 0);
    end
  end

  always @(negedge clk_in) begin
    chk1("tx_cycle", tx_out, exp_tx);
    chk1("ready_cycle", ready_out, exp_ready);
    chk1("done_cycle", done_out, exp_done);
  end

  // Line capture for decoding literal byte expectations.
  logic cap_en = 1'b0;
  logic cap_tx[$];
  logic cap_done[$];
  logic cap_rdy[$];

  always @(negedge clk_in) begin
    if (cap_en) begin
      cap_tx.push_back(tx_out);
      cap_done.push_back(done_out);
      cap_rdy.push_back(ready_out);
    end
  end

  task automatic start_cap();
    cap_tx.delete();
    cap_done.delete();
    cap_rdy.delete();
    cap_en = 1'b1;
  endtask

  task automatic send(logic [3:0] s, logic [3:0] c,
                      logic [7:0] a, logic [7:0] b);
    status = s;
    channel = c;
    data_byte1 = a;
    data_byte2 = b;
    valid_in = 1'b1;
    @(posedge clk_in);
    #2;
    valid_in = 1'b0;
  endtask

  task automatic check_msg(string nm, int n,
                           logic [7:0] e0, logic [7:0] e1, logic [7:0] e2);
    logic [7:0] eb[3];
    logic [7:0] got;
    int f, d, nd, idx;
    f = -1;
    d = -1;
    nd = 0;
    eb[0] = e0;
    eb[1] = e1;
    eb[2] = e2;
    cap_en = 1'b0;
    foreach (cap_tx[i]) if (f < 0 && cap_tx[i] === 1'b0) f = i;
    foreach (cap_done[i]) begin
      if (cap_done[i] === 1'b1) begin
        nd++;
        if (d < 0) d = i;
      end
    end
    if (f < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_start: got no start bit want one", nm);
      return;
    end
    chk_int({nm, "_span"}, d - f, n * 10 * B);
    chk_int({nm, "_ndone"}, nd, 1);
    if (d >= 0) chk1({nm, "_ready"}, cap_rdy[d], 1'b1);
    for (int k = 0; k < n; k++) begin
      got = '0;
      for (int j = 0; j < 8; j++) begin
        idx = f + k * 10 * B + (j + 1) * B + B / 2;
        got[j] = (idx < cap_tx.size()) ? cap_tx[idx] : 1'bx;
      end
      chk8($sformatf("%s_byte%0d", nm, k), got, eb[k]);
    end
  endtask

  task automatic wait_done(string nm, int limit);
    int seen;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_in);
      if (done_out === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk_int({nm, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, nr, nd;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk1("rst_ready", ready_out, 1'b1);
    chk1("rst_tx", tx_out, 1'b1);
    chk1("rst_done", done_out, 1'b0);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;

    start_cap();
    send(4'h9, 4'h0, 8'h3C, 8'h64);
    repeat (3 * 10 * B + 4) @(negedge clk_in);
    check_msg("note_on", 3, 8'h90, 8'h3C, 8'h64);

    @(posedge clk_in);
    #2;
    start_cap();
    send(4'hC, 4'h3, 8'h05, 8'h77);
    repeat (2 * 10 * B + 4) @(negedge clk_in);
    check_msg("prog", 2, 8'hC3, 8'h05, 8'h00);

    @(posedge clk_in);
    #2;
    start_cap();
    send(4'h3, 4'h0, 8'h11, 8'h22);
    repeat (10) @(negedge clk_in);
    cap_en = 1'b0;
    lo = 0;
    nr = 0;
    nd = 0;
    foreach (cap_tx[i]) begin
      if (cap_tx[i] !== 1'b1) lo++;
      if (cap_rdy[i] !== 1'b1) nr++;
      if (cap_done[i] !== 1'b0) nd++;
    end
    chk_int("invalid_tx_low", lo, 0);
    chk_int("invalid_not_ready", nr, 0);
    chk_int("invalid_done", nd, 0);

    @(posedge clk_in);
    #2;
    start_cap();
    send(4'h8, 4'h0, 8'hFF, 8'h80);
    repeat (3 * 10 * B + 4) @(negedge clk_in);
    check_msg("mask", 3, 8'h80, 8'h7F, 8'h00);

    @(posedge clk_in);
    #2;
    start_cap();
    send(4'h9, 4'h1, 8'h10, 8'h20);
    repeat (30) @(posedge clk_in);
    #2;
    send(4'hA, 4'h5, 8'h11, 8'h22);
    repeat (3 * 10 * B - 20) @(negedge clk_in);
    check_msg("busy", 3, 8'h91, 8'h10, 8'h20);

    @(posedge clk_in);
    #2;
    send(4'h9, 4'h2, 8'h40, 8'h50);
    wait_done("b2b_first", 200);
    #1;
    send(4'hB, 4'h2, 8'h07, 8'h08);
    @(negedge clk_in);
    chk1("b2b_start", tx_out, 1'b0);
    wait_done("b2b_second", 200);

    @(posedge clk_in);
    #2;
    send(4'h9, 4'h0, 8'h3C, 8'h64);
    repeat (21) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    chk1("midrst_tx", tx_out, 1'b1);
    chk1("midrst_ready", ready_out, 1'b1);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    @(posedge clk_in);
    #2;
    start_cap();
    send(4'h9, 4'h0, 8'h3C, 8'h64);
    repeat (3 * 10 * B + 4) @(negedge clk_in);
    check_msg("after_rst", 3, 8'h90, 8'h3C, 8'h64);

    @(posedge clk_in);
    #2;
    start_cap();
    send(4'h9, 4'h0, 8'h3E, 8'h40);
    repeat (3 * 10 * B + 4) @(negedge clk_in);
`ifdef MIDI_RUNNING_STATUS_EN
    check_msg("rs_repeat", 2, 8'h3E, 8'h40, 8'h00);
`else
    check_msg("rs_repeat", 3, 8'h90, 8'h3E, 8'h40);
`endif

    @(posedge clk_in);
    #2;
    start_cap();
    send(4'h9, 4'h1, 8'h3C, 8'h64);
    repeat (3 * 10 * B + 4) @(negedge clk_in);
    check_msg("rs_newch", 3, 8'h91, 8'h3C, 8'h64);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_in);
      #2;
      status = 4'($urandom_range(0, 15));
      channel = 4'($urandom_range(0, 1));
      data_byte1 = 8'($urandom);
      data_byte2 = 8'($urandom);
      valid_in = ($urandom_range(0, 5) == 0);
    end
    valid_in = 1'b0;
    repeat (3 * 10 * B + 8) @(posedge clk_in);
    @(negedge clk_in);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
